// File: rtl/block_mover_if.sv
// block_mover_if: board/request/piece-position bundle between a game
// controller (master) and block_mover (slave).
// Optional macro HARD_DROP_EN adds the hard_drop request line.
interface block_mover_if;
    localparam int unsigned BOARD_W = 128;
    localparam int unsigned XW      = 3;
    localparam int unsigned YW      = 4;

    logic [BOARD_W-1:0] board;
    logic               move_left;
    logic               move_right;
    logic               drop_tick;
`ifdef HARD_DROP_EN
    logic               hard_drop;
`endif

    logic [XW-1:0]      next_block1_x;
    logic [XW-1:0]      next_block2_x;
    logic [XW-1:0]      next_block3_x;
    logic [XW-1:0]      next_block4_x;
    logic [YW-1:0]      next_block1_y;
    logic [YW-1:0]      next_block2_y;
    logic [YW-1:0]      next_block3_y;
    logic [YW-1:0]      next_block4_y;
    logic               placed;
    logic               game_over;

    // Controller side: owns the board and the requests
    modport master (
        output board, move_left, move_right, drop_tick,
`ifdef HARD_DROP_EN
        output hard_drop,
`endif
        input  next_block1_x, next_block2_x, next_block3_x, next_block4_x,
        input  next_block1_y, next_block2_y, next_block3_y, next_block4_y,
        input  placed, game_over
    );

    // Mover side: consumes requests, owns the piece position
    modport slave (
        input  board, move_left, move_right, drop_tick,
`ifdef HARD_DROP_EN
        input  hard_drop,
`endif
        output next_block1_x, next_block2_x, next_block3_x, next_block4_x,
        output next_block1_y, next_block2_y, next_block3_y, next_block4_y,
        output placed, game_over
    );
endinterface

// File: rtl/block_mover.sv
// block_mover: moves a horizontal 4-cell piece over an 8x16 occupancy board,
// handles gravity, locking, respawn and game-over detection.
// Optional macro HARD_DROP_EN adds a hard_drop request and a DROP state that
// falls one row per cycle until blocked.
module block_mover #(
    parameter int unsigned SPAWN_X = 2
) (
    input  logic          CLK,
    input  logic          reset,
    block_mover_if.slave  bus
);
    localparam int unsigned XW    = 3;
    localparam int unsigned YW    = 4;
    localparam int unsigned NCELL = 4;
    localparam logic [XW-1:0] X_MAX = XW'(7);
    localparam logic [YW-1:0] Y_MAX = YW'(15);

    typedef enum logic [2:0] {
        ST_ACTIVE   = 3'd0,
        ST_LOCK     = 3'd1,
        ST_SPAWN    = 3'd2,
        ST_GAMEOVER = 3'd3
`ifdef HARD_DROP_EN
        ,
        ST_DROP     = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q [NCELL];
    logic [XW-1:0] x_d [NCELL];
    logic [YW-1:0] y_q [NCELL];
    logic [YW-1:0] y_d [NCELL];
    logic          placed_q, placed_d;
    logic          game_over_q, game_over_d;

    // Candidate neighbour coordinates; only used once the bounds check passes
    logic [XW-1:0] x_left  [NCELL];
    logic [XW-1:0] x_right [NCELL];
    logic [YW-1:0] y_down  [NCELL];
    logic [XW-1:0] x_spawn [NCELL];
    logic          left_ok, right_ok, down_ok, spawn_ok;

    // Legality of each move: bounds first, then board occupancy of the target
    always_comb begin
        left_ok  = 1'b1;
        right_ok = 1'b1;
        down_ok  = 1'b1;
        spawn_ok = 1'b1;
        for (int unsigned i = 0; i < NCELL; i++) begin
            x_left[i]  = x_q[i] - XW'(1);
            x_right[i] = x_q[i] + XW'(1);
            y_down[i]  = y_q[i] + YW'(1);
            x_spawn[i] = XW'(SPAWN_X + i);

            if (x_q[i] == '0) begin
                left_ok = 1'b0;
            end else if (bus.board[{y_q[i], x_left[i]}]) begin
                left_ok = 1'b0;
            end

            if (x_q[i] == X_MAX) begin
                right_ok = 1'b0;
            end else if (bus.board[{y_q[i], x_right[i]}]) begin
                right_ok = 1'b0;
            end

            if (y_q[i] == Y_MAX) begin
                down_ok = 1'b0;
            end else if (bus.board[{y_down[i], x_q[i]}]) begin
                down_ok = 1'b0;
            end

            if (bus.board[{YW'(0), x_spawn[i]}]) begin
                spawn_ok = 1'b0;
            end
        end
    end

    // Next state, next piece position, placed/game_over flags
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        game_over_d = game_over_q;

        case (state_q)
            ST_ACTIVE: begin
`ifdef HARD_DROP_EN
                if (bus.hard_drop) begin
                    if (down_ok) begin
                        y_d     = y_down;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else
`endif
                if (bus.drop_tick) begin
                    if (down_ok) begin
                        y_d = y_down;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (bus.move_left && !bus.move_right) begin
                    if (left_ok) begin
                        x_d = x_left;
                    end
                end else if (bus.move_right && !bus.move_left) begin
                    if (right_ok) begin
                        x_d = x_right;
                    end
                end
            end

            ST_LOCK: begin
                state_d = ST_SPAWN;
            end

            ST_SPAWN: begin
                if (spawn_ok) begin
                    x_d     = x_spawn;
                    for (int unsigned i = 0; i < NCELL; i++) begin
                        y_d[i] = '0;
                    end
                    state_d = ST_ACTIVE;
                end else begin
                    game_over_d = 1'b1;
                    state_d     = ST_GAMEOVER;
                end
            end

            ST_GAMEOVER: begin
                state_d = ST_GAMEOVER;
            end

`ifdef HARD_DROP_EN
            ST_DROP: begin
                if (down_ok) begin
                    y_d = y_down;
                end else begin
                    state_d = ST_LOCK;
                end
            end
`endif

            default: begin
                state_d = ST_ACTIVE;
            end
        endcase

        // placed is low for exactly the cycle spent in LOCK
        placed_d = (state_d != ST_LOCK);
    end

    // State and output registers; reset returns the piece to spawn at once
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACTIVE;
            placed_q    <= 1'b1;
            game_over_q <= 1'b0;
            for (int unsigned i = 0; i < NCELL; i++) begin
                x_q[i] <= XW'(SPAWN_X + i);
                y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            placed_q    <= placed_d;
            game_over_q <= game_over_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    // Drive the bus from the registered position and flags
    assign bus.next_block1_x = x_q[0];
    assign bus.next_block2_x = x_q[1];
    assign bus.next_block3_x = x_q[2];
    assign bus.next_block4_x = x_q[3];
    assign bus.next_block1_y = y_q[0];
    assign bus.next_block2_y = y_q[1];
    assign bus.next_block3_y = y_q[2];
    assign bus.next_block4_y = y_q[3];
    assign bus.placed        = placed_q;
    assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover: directed test of block_mover with hand-computed piece
// positions. Define HARD_DROP_EN to also exercise the hard-drop path.
module tb_block_mover;
    logic CLK;
    logic reset;
    int   n_cmp;
    int   n_err;

    block_mover_if bus ();

    block_mover #(
        .SPAWN_X (2)
    ) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count one comparison and report it if it does not match
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected packed {x1..x4, y1..y4} for a horizontal piece at (x0, y)
    function automatic logic [31:0] piece_at(input int x0, input int y);
        return {4'h0, 3'(x0), 3'(x0 + 1), 3'(x0 + 2), 3'(x0 + 3),
                4'(y), 4'(y), 4'(y), 4'(y)};
    endfunction

    function automatic logic [31:0] piece_now();
        return {4'h0, bus.next_block1_x, bus.next_block2_x, bus.next_block3_x,
                bus.next_block4_x, bus.next_block1_y, bus.next_block2_y,
                bus.next_block3_y, bus.next_block4_y};
    endfunction

    // One clock with the given requests held; outputs settle 1 time unit later
    task automatic cyc(input logic l, input logic r, input logic d, input logic h);
        @(negedge CLK);
        bus.move_left  = l;
        bus.move_right = r;
        bus.drop_tick  = d;
`ifdef HARD_DROP_EN
        bus.hard_drop  = h;
`endif
        @(posedge CLK);
        #1;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        bus.drop_tick  = 1'b0;
`ifdef HARD_DROP_EN
        bus.hard_drop  = 1'b0;
`endif
    endtask

    // Assert reset mid-cycle, check the immediate effect, release before next edge
    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check_eq({tag, "_rst_pos"}, piece_now(), piece_at(2, 0));
        check_eq({tag, "_rst_placed"}, 32'(bus.placed), 32'd1);
        check_eq({tag, "_rst_go"}, 32'(bus.game_over), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] brd;
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.board      = '0;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        bus.drop_tick  = 1'b0;
`ifdef HARD_DROP_EN
        bus.hard_drop  = 1'b0;
`endif
        #3;
        check_eq("por_pos", piece_now(), piece_at(2, 0));
        check_eq("por_placed", 32'(bus.placed), 32'd1);
        check_eq("por_go", 32'(bus.game_over), 32'd0);
        @(negedge CLK);
        reset = 1'b0;

        // Left moves down to the wall, then blocked
        cyc(1, 0, 0, 0); check_eq("left1", piece_now(), piece_at(1, 0));
        cyc(1, 0, 0, 0); check_eq("left2", piece_now(), piece_at(0, 0));
        cyc(1, 0, 0, 0); check_eq("left_wall", piece_now(), piece_at(0, 0));
        cyc(1, 1, 0, 0); check_eq("lr_both", piece_now(), piece_at(0, 0));
        cyc(0, 1, 0, 0); check_eq("right1", piece_now(), piece_at(1, 0));

        // Gravity to the floor, then lock on the 16th tick
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        check_eq("floor_pos", piece_now(), piece_at(1, 15));
        check_eq("floor_placed", 32'(bus.placed), 32'd1);
        cyc(0, 0, 1, 0);
        check_eq("lock_placed", 32'(bus.placed), 32'd0);
        check_eq("lock_pos", piece_now(), piece_at(1, 15));
        brd = '0;
        for (int x = 1; x <= 4; x++) brd[15*8 + x] = 1'b1;
        bus.board = brd;
        cyc(1, 0, 0, 0);
        check_eq("spawn_placed", 32'(bus.placed), 32'd1);
        check_eq("spawn_hold", piece_now(), piece_at(1, 15));
        cyc(1, 0, 0, 0);
        check_eq("respawn", piece_now(), piece_at(2, 0));
        cyc(0, 0, 0, 0);
        check_eq("no_queue", piece_now(), piece_at(2, 0));

        // Right moves up to the wall, then blocked
        cyc(0, 1, 0, 0); check_eq("right2", piece_now(), piece_at(3, 0));
        cyc(0, 1, 0, 0); check_eq("right3", piece_now(), piece_at(4, 0));
        cyc(0, 1, 0, 0); check_eq("right_wall", piece_now(), piece_at(4, 0));

        // Drop beats left; empty board so the drop is legal
        pulse_reset("r1");
        bus.board = '0;
        cyc(1, 0, 1, 0); check_eq("drop_wins", piece_now(), piece_at(2, 1));
        cyc(0, 0, 0, 0); check_eq("drop_idle", piece_now(), piece_at(2, 1));

        // Blocked cell below: drop locks with no y change, left ignored
        pulse_reset("r2");
        brd = '0;
        brd[1*8 + 3] = 1'b1;
        bus.board = brd;
        cyc(1, 0, 1, 0);
        check_eq("blk_lock_pos", piece_now(), piece_at(2, 0));
        check_eq("blk_lock_placed", 32'(bus.placed), 32'd0);
        pulse_reset("r3");

        // Blocked spawn: game over, everything frozen until reset
        brd[0*8 + 4] = 1'b1;
        bus.board = brd;
        cyc(0, 0, 1, 0); check_eq("go_lock", 32'(bus.placed), 32'd0);
        cyc(0, 0, 0, 0); check_eq("go_spawn_go", 32'(bus.game_over), 32'd0);
        cyc(0, 0, 0, 0); check_eq("go_set", 32'(bus.game_over), 32'd1);
        check_eq("go_pos", piece_now(), piece_at(2, 0));
        cyc(0, 1, 0, 0); check_eq("go_right", piece_now(), piece_at(2, 0));
        bus.board = '0;
        cyc(0, 0, 1, 0); check_eq("go_drop", piece_now(), piece_at(2, 0));
        check_eq("go_sticky", 32'(bus.game_over), 32'd1);
        pulse_reset("r4");
        cyc(0, 0, 1, 0); check_eq("post_go", piece_now(), piece_at(2, 1));

`ifdef HARD_DROP_EN
        // Hard drop falls one row per cycle, ignoring other requests
        pulse_reset("r5");
        cyc(0, 0, 0, 1); check_eq("hd_first", piece_now(), piece_at(2, 1));
        cyc(1, 0, 0, 0); check_eq("hd_ignore", piece_now(), piece_at(2, 2));
        for (int i = 0; i < 13; i++) cyc(0, 0, 0, 0);
        check_eq("hd_floor", piece_now(), piece_at(2, 15));
        check_eq("hd_floor_placed", 32'(bus.placed), 32'd1);
        cyc(0, 0, 0, 0); check_eq("hd_lock", 32'(bus.placed), 32'd0);

        // Reset mid-drop cancels it
        pulse_reset("r6");
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check_eq("hd_c5", piece_now(), piece_at(2, 5));
        pulse_reset("r7");
        cyc(0, 0, 0, 0); check_eq("hd_cancel", piece_now(), piece_at(2, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1);
    end

endmodule
